// File: rtl/alu_seq_pipe_pkg.sv
// Shared encodings for the sequential ALU: unit classes, per-class op codes,
// compare result codes and the control FSM states.
package alu_seq_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_CMP   = 2'b10,
    CLS_SHIFT = 2'b11
  } alu_class_e;

  localparam logic [1:0] OP_ADD  = 2'd0, OP_SUB = 2'd1, OP_MUL  = 2'd2, OP_DIV = 2'd3;
  localparam logic [1:0] OP_AND  = 2'd0, OP_OR  = 2'd1, OP_NAND = 2'd2, OP_NOR = 2'd3;
  localparam logic [1:0] OP_NOP  = 2'd0, OP_EQ  = 2'd1, OP_GT   = 2'd2, OP_LT  = 2'd3;
  localparam logic [1:0] OP_SRL  = 2'd0, OP_SLL = 2'd1, OP_SRA  = 2'd2, OP_ROL = 2'd3;

  localparam logic [1:0] CMP_RES_EQ = 2'd1;
  localparam logic [1:0] CMP_RES_GT = 2'd2;
  localparam logic [1:0] CMP_RES_LT = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_pipe_divider.sv
// Signed restoring divider: one quotient bit per cycle on operand magnitudes,
// signs applied at the end (truncation toward zero). The first iteration runs on accept.
module alu_seq_pipe_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic             neg_q, neg_r;
  logic             go;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_in, q_in, d_in, r_step, q_step;
  logic [WIDTH:0]   shifted, trial;

  assign dz    = (b == '0);
  assign go    = start & ~dz & ~busy;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    r_in    = go ? '0    : r_q;
    q_in    = go ? a_mag : q_q;
    d_in    = go ? b_mag : d_q;
    shifted = {r_in, q_in[WIDTH-1]};
    trial   = shifted - {1'b0, d_in};
    // A set top bit means the trial subtraction borrowed: restore the shifted remainder.
    r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_step  = {q_in[WIDTH-2:0], ~trial[WIDTH]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too; they are few and it keeps outputs deterministic.
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (go) begin
      busy  <= 1'b1;
      cnt   <= CNT_W'(WIDTH - 1);
      r_q   <= r_step;
      q_q   <= q_step;
      d_q   <= b_mag;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        r_q <= r_step;
        q_q <= q_step;
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign done = busy & (cnt == '0);
  assign quot = neg_q ? -q_q : q_q;
  assign rem  = neg_r ? -r_q : r_q;

endmodule

// File: rtl/alu_seq_pipe.sv
// Sequential ALU with valid/ready handshakes, one shared registered result path,
// single-cycle arith/logic/compare/shift units and a multi-cycle signed divider.
module alu_seq_pipe
  import alu_seq_pipe_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_fun,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] alu_out,
  output logic [1:0]         out_class,
  output logic               zero_flag,
  output logic               ovf_flag,
  output logic               dz_flag
);

  localparam int W2 = 2 * WIDTH;

  state_e                  state, state_next;
  alu_class_e              cls;
  logic [1:0]              op;
  logic                    accept, is_div, div_start, load_op;
  logic                    div_busy, div_done, div_dz;
  logic [WIDTH-1:0]        div_quot, div_rem;
  logic [W2-1:0]           res;
  logic                    res_ovf, res_dz;
  logic [WIDTH-1:0]        sum, diff, shift_v;
  logic [SHAMT_W-1:0]      shamt;
  logic signed [W2-1:0]    a_ext, b_ext, prod;
  logic [W2-1:0]           rol_wide;

  assign cls      = alu_class_e'(alu_fun[3:2]);
  assign op       = alu_fun[1:0];
  assign shamt    = b[SHAMT_W-1:0];
  assign sum      = a + b;
  assign diff     = a - b;
  assign a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext    = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign rol_wide = {a, a} << shamt;

  assign in_ready  = (state == ST_IDLE) & ~div_busy & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_div    = (cls == CLS_ARITH) && (op == OP_DIV);
  // Divide by zero skips the divider and completes like any single-cycle op.
  assign div_start = accept & is_div & ~div_dz;
  assign load_op   = accept & ~div_start;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    shift_v = '0;
    case (cls)
      CLS_ARITH: case (op)
        OP_ADD: begin
          res     = {{WIDTH{sum[WIDTH-1]}}, sum};
          res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          res     = {{WIDTH{diff[WIDTH-1]}}, diff};
          res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_MUL: res = prod;
        OP_DIV: begin
          res    = {a, {WIDTH{1'b1}}};
          res_dz = 1'b1;
        end
      endcase
      CLS_LOGIC: case (op)
        OP_AND:  res = {{WIDTH{1'b0}}, a & b};
        OP_OR:   res = {{WIDTH{1'b0}}, a | b};
        OP_NAND: res = {{WIDTH{1'b0}}, ~(a & b)};
        OP_NOR:  res = {{WIDTH{1'b0}}, ~(a | b)};
      endcase
      CLS_CMP: case (op)
        OP_NOP: res = '0;
        OP_EQ:  res = (a == b) ? W2'(CMP_RES_EQ) : '0;
        OP_GT:  res = ($signed(a) > $signed(b)) ? W2'(CMP_RES_GT) : '0;
        OP_LT:  res = ($signed(a) < $signed(b)) ? W2'(CMP_RES_LT) : '0;
      endcase
      CLS_SHIFT: begin
        case (op)
          OP_SRL: shift_v = a >> shamt;
          OP_SLL: shift_v = a << shamt;
          OP_SRA: shift_v = $signed(a) >>> shamt;
          OP_ROL: shift_v = rol_wide[W2-1:WIDTH];
        endcase
        res = {{WIDTH{1'b0}}, shift_v};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (div_start) state_next = ST_DIV;
      ST_DIV:  if (div_done)  state_next = ST_IDLE;
    endcase
  end

  // The output is empty whenever the divider finishes, so the two load sources never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      out_class <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      dz_flag   <= 1'b0;
    end else if (load_op) begin
      out_valid <= 1'b1;
      alu_out   <= res;
      out_class <= cls;
      zero_flag <= (res == '0);
      ovf_flag  <= res_ovf;
      dz_flag   <= res_dz;
    end else if (div_done) begin
      out_valid <= 1'b1;
      alu_out   <= {div_rem, div_quot};
      out_class <= CLS_ARITH;
      zero_flag <= ({div_rem, div_quot} == '0);
      ovf_flag  <= 1'b0;
      dz_flag   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  alu_seq_pipe_divider #(.WIDTH(WIDTH)) u_divider (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (a),
    .b     (b),
    .busy  (div_busy),
    .done  (div_done),
    .dz    (div_dz),
    .quot  (div_quot),
    .rem   (div_rem)
  );

endmodule
